// File: rtl/dut_pkg.sv
// Shared opcode, FSM state, error-code and latency definitions for tiny_alu_core.
// The latency helper keeps the muldiv step count and the core commit cycle consistent.
package dut_pkg;

    typedef enum logic [7:0] {
        OP_NOP = 8'd0,
        OP_ADD = 8'd1,
        OP_AND = 8'd2,
        OP_XOR = 8'd3,
        OP_MUL = 8'd4,
        OP_DIV = 8'd5,
        OP_LDA = 8'd6,
        OP_STA = 8'd7,
        OP_MOV = 8'd8,
        OP_SWP = 8'd9,
        OP_WMR = 8'd10
    } operation_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_DIV,
        ST_CLR,
        ST_DONE
    } state_t;

    localparam logic [7:0] ERR_NONE    = 8'd0;
    localparam logic [7:0] ERR_ILLEGAL = 8'd1;
    localparam logic [7:0] ERR_DIV0    = 8'd2;
    localparam logic [7:0] ERR_ADDR    = 8'd3;

    localparam int LAT_SHORT = 1;

    // Capture-to-done cycles of mul/div: one step per operand bit plus the commit cycle.
    function automatic int muldiv_latency(input int data_w);
        return data_w + LAT_SHORT;
    endfunction

endpackage

// File: rtl/tiny_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, sign fixed at the output.
// start_i accepted only when not busy; done_o pulses DATA_W cycles after the start edge.
module tiny_alu_muldiv
    import dut_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  is_div_i,
    input  logic                  sv_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   result_o
);
    localparam int STEPS = muldiv_latency(DATA_W) - LAT_SHORT;
    localparam int CW    = $clog2(STEPS + 1);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] mb_q, mb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              div_q, div_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;

    logic [DATA_W-1:0]   mag_a, mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_sh, div_dif;
    logic                div_ge;
    logic [DATA_W-1:0]   quo, rem;
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        mag_a   = (sv_i && a_i[DATA_W-1]) ? -a_i : a_i;
        mag_b   = (sv_i && b_i[DATA_W-1]) ? -b_i : b_i;
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : '0);
        div_sh  = {hi_q, lo_q[DATA_W-1]};
        div_dif = div_sh - {1'b0, mb_q};
        div_ge  = ~div_dif[DATA_W];

        hi_d   = hi_q;
        lo_d   = lo_q;
        mb_d   = mb_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        div_d  = div_q;
        negq_d = negq_q;
        negr_d = negr_q;

        if (busy_q) begin
            if (div_q) begin
                hi_d = div_ge ? div_dif[DATA_W-1:0] : div_sh[DATA_W-1:0];
                lo_d = {lo_q[DATA_W-2:0], div_ge};
            end else begin
                hi_d = mul_sum[DATA_W:1];
                lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else if (start_i) begin
            hi_d   = '0;
            lo_d   = mag_a;
            mb_d   = mag_b;
            cnt_d  = CW'(STEPS);
            busy_d = 1'b1;
            div_d  = is_div_i;
            negq_d = sv_i && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
            // Remainder follows the dividend sign so the quotient truncates toward zero.
            negr_d = sv_i && a_i[DATA_W-1];
        end
    end

    always_comb begin
        quo  = negq_q ? -lo_q : lo_q;
        rem  = negr_q ? -hi_q : hi_q;
        prod = {hi_q, lo_q};
        result_o = div_q ? {rem, quo} : (negq_q ? -prod : prod);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            mb_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            div_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            mb_q   <= mb_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            div_q  <= div_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/tiny_alu_core.sv
// Single-command ALU with scratch memory and accumulator; start is a held level, re-armed when low.
// One-cycle done pulse: 1 cycle for simple ops, DATA_W+1 for mul/div, MEM_DEPTH for memory clear.
module tiny_alu_core
    import dut_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            op,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    input  logic                  sv,
    input  logic                  op_prefix,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result,
    output logic [7:0]            err,
    output logic                  gp
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int RW = 2 * DATA_W;

    state_t            state_q, state_d;
    logic              armed_q, armed_d;
    logic [7:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              sv_q, sv_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic [RW-1:0]     result_q;
    logic [7:0]        err_q;
    logic              gp_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    logic [DATA_W-1:0] b_eff;
    logic              a_ok, b_ok;
    logic [AW-1:0]     a_idx, b_idx;
    logic [DATA_W:0]   sum_u, sum_s;
    logic              commit;
    logic [RW-1:0]     res_n;
    logic [7:0]        err_n;
    logic              gp_n;
    logic              wr0_en, wr1_en;
    logic [AW-1:0]     wr0_addr, wr1_addr;
    logic [DATA_W-1:0] wr0_dat, wr1_dat;
    logic              md_start, md_busy, md_done;
    logic [RW-1:0]     md_result;

    assign b_eff = op_prefix ? acc_q : B;
    assign a_ok  = a_q < DATA_W'(MEM_DEPTH);
    assign b_ok  = b_q < DATA_W'(MEM_DEPTH);
    assign a_idx = a_q[AW-1:0];
    assign b_idx = b_q[AW-1:0];
    assign sum_u = {1'b0, a_q} + {1'b0, b_q};
    assign sum_s = {a_q[DATA_W-1], a_q} + {b_q[DATA_W-1], b_q};

    tiny_alu_muldiv #(.DATA_W(DATA_W)) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (md_start),
        .is_div_i (op == OP_DIV),
        .sv_i     (sv),
        .a_i      (A),
        .b_i      (b_eff),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q | ~start;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        sv_d      = sv_q;
        clr_idx_d = clr_idx_q;
        md_start  = 1'b0;
        commit    = 1'b0;
        res_n     = '0;
        err_n     = ERR_NONE;
        wr0_en    = 1'b0;
        wr0_addr  = a_idx;
        wr0_dat   = b_q;
        wr1_en    = 1'b0;
        wr1_addr  = b_idx;
        wr1_dat   = mem_q[a_idx];

        unique case (state_q)
            ST_IDLE: begin
                if (start && armed_q) begin
                    armed_d   = 1'b0;
                    op_d      = op;
                    a_d       = A;
                    b_d       = b_eff;
                    sv_d      = sv;
                    clr_idx_d = '0;
                    case (op)
                        OP_MUL: begin
                            state_d  = ST_MUL;
                            md_start = ~md_busy;
                        end
                        OP_DIV: begin
                            if (b_eff != '0) begin
                                state_d  = ST_DIV;
                                md_start = ~md_busy;
                            end else begin
                                state_d = ST_EXEC;
                            end
                        end
                        OP_WMR:  state_d = ST_CLR;
                        default: state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                commit = 1'b1;
                case (op_q)
                    OP_NOP: res_n = '0;
                    OP_ADD: res_n = sv_q ? {{(DATA_W-1){sum_s[DATA_W]}}, sum_s}
                                         : {{(DATA_W-1){1'b0}}, sum_u};
                    OP_AND: res_n = RW'(a_q & b_q);
                    OP_XOR: res_n = RW'(a_q ^ b_q);
                    // Only a zero divisor is finished here; real divides go through ST_DIV.
                    OP_DIV: err_n = ERR_DIV0;
                    OP_LDA: begin
                        if (a_ok) res_n = RW'(mem_q[a_idx]);
                        else      err_n = ERR_ADDR;
                    end
                    OP_STA: begin
                        if (a_ok) begin
                            wr0_en = 1'b1;
                            res_n  = RW'(b_q);
                        end else begin
                            err_n = ERR_ADDR;
                        end
                    end
                    OP_MOV: begin
                        if (a_ok && b_ok) begin
                            wr0_en  = 1'b1;
                            wr0_dat = mem_q[b_idx];
                            res_n   = RW'(mem_q[b_idx]);
                        end else begin
                            err_n = ERR_ADDR;
                        end
                    end
                    OP_SWP: begin
                        if (a_ok && b_ok) begin
                            wr0_en  = 1'b1;
                            wr0_dat = mem_q[b_idx];
                            wr1_en  = 1'b1;
                            res_n   = {mem_q[b_idx], mem_q[a_idx]};
                        end else begin
                            err_n = ERR_ADDR;
                        end
                    end
                    default: err_n = ERR_ILLEGAL;
                endcase
            end
            ST_MUL, ST_DIV: begin
                if (md_done) begin
                    commit = 1'b1;
                    res_n  = md_result;
                end
            end
            ST_CLR: begin
                wr0_en    = 1'b1;
                wr0_addr  = clr_idx_q;
                wr0_dat   = '0;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(MEM_DEPTH - LAT_SHORT)) commit = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (commit) state_d = ST_DONE;
    end

    assign gp_n = (err_n == ERR_NONE) && (res_n != '0) && !(sv_q && res_n[RW-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b1;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sv_q      <= 1'b0;
            clr_idx_q <= '0;
            result_q  <= '0;
            err_q     <= ERR_NONE;
            gp_q      <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sv_q      <= sv_d;
            clr_idx_q <= clr_idx_d;
            if (commit) begin
                result_q <= res_n;
                err_q    <= err_n;
                gp_q     <= gp_n;
                acc_q    <= res_n[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr0_en) mem_q[wr0_addr] <= wr0_dat;
            if (wr1_en) mem_q[wr1_addr] <= wr1_dat;
        end
    end

    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign err    = err_q;
    assign gp     = gp_q;

endmodule

// File: doc/tiny_alu_core.md
TINY_ALU_CORE -- requirements
Module: tiny_alu_core

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, operand width; result width SHALL be 2*DATA_W.
REQ-002 The block SHALL have parameter MEM_DEPTH, default 16, number of scratch-memory words (DATA_W bits each).
REQ-003 The block SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  in  1  command request, held high by the initiator until done is seen.
REQ-006 The block SHALL have port op  in  8  opcode: 0 nop, 1 add, 2 and, 3 xor, 4 mul, 5 div, 6 lda, 7 sta, 8 mov, 9 swp, 10 wmr.
REQ-007 The block SHALL have ports A, B  in  DATA_W each  operands; A is also address (lda/sta/mov/swp), B second address (mov/swp).
REQ-008 The block SHALL have port sv  in  1  1 = signed arithmetic, 0 = unsigned.
REQ-009 The block SHALL have port op_prefix  in  1  1 = replace B with accumulator (low DATA_W bits of last result).
REQ-010 The block SHALL have ports done  out  1  one-cycle completion pulse; result  out  2*DATA_W; err  out  8; gp  out  1  positive-result flag.

Function
REQ-011 States SHALL be IDLE, EXEC, MUL, DIV, CLR, DONE.
REQ-012 In IDLE, start=1 with armed=1 SHALL latch op/A/B/sv/op_prefix (capture edge C) and clear armed; armed SHALL set when start is sampled 0.
REQ-013 start SHALL be ignored outside IDLE; a start held high after done SHALL NOT re-trigger.
REQ-014 done SHALL be 1 for exactly one cycle; result/err/gp SHALL update on that edge and hold until the next done.
REQ-015 Latency C->done: ops 0-3, 6-9 and illegal = 1; mul = 33; div = 33; wmr = MEM_DEPTH.
REQ-016 add: sv=0 result = zero-extended 33-bit sum; sv=1 result = sign-extended sum of sign-extended operands.
REQ-017 and/xor: zero-extended DATA_W result; nop: result 0.
REQ-018 mul: iterative shift-add, full 2*DATA_W product, signed when sv=1.
REQ-019 div: iterative restoring; result = {remainder, quotient}; signed truncates toward zero, remainder takes dividend sign; MIN/-1 gives quotient 0x80000000, remainder 0.
REQ-020 div with B=0: err=2, result=0, latency 1.
REQ-021 lda: result = mem[A]; sta: mem[A]<=B, result=B; mov: mem[A]<=mem[B], result=moved word; swp: exchange mem[A], mem[B] in one edge, result={old mem[B], old mem[A]}.
REQ-022 Any address >= MEM_DEPTH SHALL give err=3, result=0, no memory write.
REQ-023 wmr: CLR state zeroes one word per cycle from 0 upward; result=0.
REQ-024 Opcode > 10: err=1, result=0, no state change except accumulator.
REQ-025 err=0 on success; gp = (err==0) && result!=0 && !(sv && result[2*DATA_W-1]).
REQ-026 Accumulator SHALL load result low DATA_W bits at every done.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, done=0, result=0, err=0, gp=0, accumulator=0, armed=1, all memory words 0, aborting any operation.
REQ-028 After reset release, the first start=1 sample SHALL be accepted.

Structure
REQ-029 operation_t enum, err code constants (ERR_NONE=0, ERR_ILLEGAL=1, ERR_DIV0=2, ERR_ADDR=3) and latency constants SHALL live in dut_pkg.
REQ-030 The iterative multiply/divide datapath SHALL be sub-module tiny_alu_muldiv with its own start/busy/done handshake.

Verification
REQ-031 add sv=1 A=-5 B=3 -> done at C+1, result=0xFFFFFFFFFFFFFFFE, err=0, gp=0.
REQ-032 mul sv=0 A=0xFFFFFFFF B=2 -> done at C+33, result=0x1FFFFFFFE, gp=1; div sv=1 A=-7 B=2 -> result={-1,-3} i.e. 0xFFFFFFFFFFFFFFFD, err=0.
REQ-033 div B=0 -> err=2, result=0; op=11 -> err=1; lda A=16 -> err=3.
REQ-034 sta A=3 B=0x55, swp A=3 B=4, lda A=4 -> 0x55; then wmr, lda A=4 -> 0, wmr done at C+16.
REQ-035 add A=1 B=1, then add op_prefix=1 A=5 -> result 7; start held high 5 cycles after done -> no second done.
REQ-036 reset asserted mid-mul (C+10) -> done never pulses, outputs 0, next add completes normally.
